// File: rtl/div_pkg.sv
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types, sizes and helpers for the multicycle divider.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } div_state_e;

   // Magnitude of a two's-complement value; the most negative value maps to itself.
   function automatic logic [DIV_WIDTH-1:0] div_abs(input logic [DIV_WIDTH-1:0] v);
      return v[DIV_WIDTH-1] ? -v : v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
//  Module      : div_step
//  Description : One combinational restoring-division iteration on {rem, quo}.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0] w_rem_sh;
   logic [WIDTH:0] w_trial;

   // Shifted remainder needs WIDTH+1 bits: an unsigned divisor can exceed 2^(WIDTH-1).
   assign w_rem_sh = {rem_i, quo_i[WIDTH-1]};
   assign w_trial  = w_rem_sh - {1'b0, dvs_i};

   assign rem_o = w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
   assign quo_o = {quo_i[WIDTH-2:0], ~w_trial[WIDTH]};

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
//  Module      : div_unit
//  Description : Multicycle signed restoring divider, one quotient bit per clock.
//                Optional DIV_UNSIGNED_EN adds a div_unsigned input for DIVU.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
`ifdef DIV_UNSIGNED_EN
   input  logic             div_unsigned,
`endif
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi,
   output logic             busy,
   output logic             done,
   output logic             div0
);

   localparam int CNT_W = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH) + 1;

   div_state_e       state_q;
   logic [WIDTH-1:0] rem_q, quo_q, dvs_q, lo_q, hi_q;
   logic [CNT_W-1:0] cnt_q;
   logic             neg_quo_q, neg_rem_q, busy_q, done_q, div0_q;
   logic [WIDTH-1:0] rem_d, quo_d;

   logic             w_signed, w_dvd_neg, w_dvs_neg;
   logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag;

`ifdef DIV_UNSIGNED_EN
   assign w_signed = ~div_unsigned;
`else
   assign w_signed = 1'b1;
`endif

   assign w_dvd_neg = w_signed & dividend[WIDTH-1];
   assign w_dvs_neg = w_signed & divisor[WIDTH-1];
   assign w_dvd_mag = w_dvd_neg ? WIDTH'(div_abs(DIV_WIDTH'($signed(dividend)))) : dividend;
   assign w_dvs_mag = w_dvs_neg ? WIDTH'(div_abs(DIV_WIDTH'($signed(divisor)))) : divisor;

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .dvs_i (dvs_q),
      .rem_o (rem_d),
      .quo_o (quo_d)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         cnt_q     <= '0;
         lo_q      <= '0;
         hi_q      <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         div0_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         div0_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if (divisor == '0) begin
                     div0_q <= 1'b1;
                  end else begin
                     rem_q     <= '0;
                     quo_q     <= w_dvd_mag;
                     dvs_q     <= w_dvs_mag;
                     neg_quo_q <= w_dvd_neg ^ w_dvs_neg;
                     neg_rem_q <= w_dvd_neg;
                     cnt_q     <= '0;
                     busy_q    <= 1'b1;
                     state_q   <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_q <= ST_FIX;
               end
            end
            ST_FIX: begin
               lo_q    <= neg_quo_q ? -quo_q : quo_q;
               hi_q    <= neg_rem_q ? -rem_q : rem_q;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign lo   = lo_q;
   assign hi   = hi_q;
   assign busy = busy_q;
   assign done = done_q;
   assign div0 = div0_q;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
//  Module      : tb_div_unit
//  Description : Self-checking bench for div_unit with an expected-result queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] lo;
   logic [31:0] hi;
   logic        busy;
   logic        done;
   logic        div0;
`ifdef DIV_UNSIGNED_EN
   logic        div_unsigned;
`endif

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   div_unit dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
`ifdef DIV_UNSIGNED_EN
      .div_unsigned (div_unsigned),
`endif
      .dividend     (dividend),
      .divisor      (divisor),
      .lo           (lo),
      .hi           (hi),
      .busy         (busy),
      .done         (done),
      .div0         (div0)
   );

   always #5 clk = ~clk;

   // 64-bit arithmetic keeps the INT_MIN / -1 case well defined.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input bit uns);
      logic signed [63:0] sa, sbv, q, r;
      exp_t e;
      if (uns) begin
         sa  = {32'd0, a};
         sbv = {32'd0, b};
      end else begin
         sa  = $signed(a);
         sbv = $signed(b);
      end
      q    = sa / sbv;
      r    = sa % sbv;
      e.lo = q[31:0];
      e.hi = r[31:0];
      return e;
   endfunction

   // Called on a falling edge; returns on the falling edge after the start edge.
   task automatic launch(input logic [31:0] a, input logic [31:0] b, input bit uns);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
`ifdef DIV_UNSIGNED_EN
      div_unsigned = uns;
`endif
      if (b != 32'd0) sb.push_back(model(a, b, uns));
      @(negedge clk);
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
   endtask

   // Bounded wait; lat=0 means done never arrived.
   task automatic wait_done(output int lat);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      dividend = '0;
      divisor  = '0;
`ifdef DIV_UNSIGNED_EN
      div_unsigned = 1'b0;
`endif
      @(negedge clk);
      n_tests++;
      if ({lo, hi, busy, done, div0} !== 67'd0)
         begin n_fail++; $display("FAIL reset_state: got lo=%h hi=%h busy=%b done=%b div0=%b, want all zero", lo, hi, busy, done, div0); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_signed();
      logic [31:0] ta[11];
      logic [31:0] tb[11];
      int lat;
      exp_t e;
      ta = '{32'd7, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd0, 32'h80000000, 32'd100, 32'hFFFFFF9C, 32'd0, 32'd0, 32'd0};
      tb = '{32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd5, 32'd3, 32'd7, 32'hFFFFFFF9, 32'd0, 32'd0, 32'd0};
      for (int i = 8; i < 11; i++) begin
         ta[i] = $urandom;
         tb[i] = $urandom | 32'd1;
      end
      for (int i = 0; i < 11; i++) begin
         launch(ta[i], tb[i], 1'b0);
         n_tests++;
         if (busy !== 1'b1)
            begin n_fail++; $display("FAIL busy_after_start[%0d]: got %b want 1", i, busy); end
         wait_done(lat);
         n_tests++;
         if (lat != 33)
            begin n_fail++; $display("FAIL latency[%0d]: got %0d want 33", i, lat); end
         n_tests++;
         if (busy !== 1'b0 || div0 !== 1'b0)
            begin n_fail++; $display("FAIL flags_at_done[%0d]: got busy=%b div0=%b want 0 0", i, busy, div0); end
         e = sb.pop_front();
         n_tests++;
         if (lo !== e.lo || hi !== e.hi)
            begin n_fail++; $display("FAIL result[%0d] %h/%h: got lo=%h hi=%h want lo=%h hi=%h", i, ta[i], tb[i], lo, hi, e.lo, e.hi); end
      end
   endtask

   task automatic test_div0();
      int lat;
      bit bad;
      exp_t e;
      launch(32'd7, 32'd2, 1'b0);
      wait_done(lat);
      e = sb.pop_front();
      n_tests++;
      if (lat == 0 || lo !== e.lo || hi !== e.hi)
         begin n_fail++; $display("FAIL div0_preload: got lat=%0d lo=%h hi=%h want lo=%h hi=%h", lat, lo, hi, e.lo, e.hi); end
      launch(32'd5, 32'd0, 1'b0);
      n_tests++;
      if (div0 !== 1'b1 || done !== 1'b0 || busy !== 1'b0)
         begin n_fail++; $display("FAIL div0_pulse: got div0=%b done=%b busy=%b want 1 0 0", div0, done, busy); end
      bad = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (div0 || done || busy) bad = 1'b1;
      end
      n_tests++;
      if (bad)
         begin n_fail++; $display("FAIL div0_quiet: got extra div0/done/busy activity want none"); end
      n_tests++;
      if (lo !== 32'd3 || hi !== 32'd1)
         begin n_fail++; $display("FAIL div0_hold: got lo=%h hi=%h want lo=00000003 hi=00000001", lo, hi); end
   endtask

   task automatic test_busy_ignore();
      int lat;
      bit bad;
      exp_t e;
      launch(32'd100, 32'd7, 1'b0);
      repeat (9) @(negedge clk);
      dividend = 32'd9;
      divisor  = 32'd3;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      wait_done(lat);
      n_tests++;
      if (lat != 23)
         begin n_fail++; $display("FAIL ignore_latency: got %0d want 23", lat); end
      e = sb.pop_front();
      n_tests++;
      if (lo !== e.lo || hi !== e.hi)
         begin n_fail++; $display("FAIL ignore_result: got lo=%h hi=%h want lo=%h hi=%h", lo, hi, e.lo, e.hi); end
      bad = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done || busy) bad = 1'b1;
      end
      n_tests++;
      if (bad)
         begin n_fail++; $display("FAIL ignore_no_second_op: got done/busy activity want none"); end
   endtask

   task automatic test_reset_mid();
      int lat;
      exp_t e;
      launch(32'd100, 32'd7, 1'b0);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      #1;
      n_tests++;
      if (lo !== 32'd0 || hi !== 32'd0 || busy !== 1'b0 || done !== 1'b0)
         begin n_fail++; $display("FAIL reset_mid: got lo=%h hi=%h busy=%b done=%b want 0 0 0 0", lo, hi, busy, done); end
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      launch(32'd9, 32'd3, 1'b0);
      wait_done(lat);
      e = sb.pop_front();
      n_tests++;
      if (lat != 33 || lo !== e.lo || hi !== e.hi)
         begin n_fail++; $display("FAIL reset_recover: got lat=%0d lo=%h hi=%h want lat=33 lo=%h hi=%h", lat, lo, hi, e.lo, e.hi); end
   endtask

   task automatic test_back_to_back();
      int lat;
      exp_t e;
      launch(32'd20, 32'd3, 1'b0);
      wait_done(lat);
      e = sb.pop_front();
      n_tests++;
      if (lat != 33 || lo !== e.lo || hi !== e.hi)
         begin n_fail++; $display("FAIL b2b_first: got lat=%0d lo=%h hi=%h want lat=33 lo=%h hi=%h", lat, lo, hi, e.lo, e.hi); end
      launch(32'hFFFFFFEC, 32'd3, 1'b0);
      wait_done(lat);
      e = sb.pop_front();
      n_tests++;
      if (lat != 33 || lo !== e.lo || hi !== e.hi)
         begin n_fail++; $display("FAIL b2b_second: got lat=%0d lo=%h hi=%h want lat=33 lo=%h hi=%h", lat, lo, hi, e.lo, e.hi); end
   endtask

`ifdef DIV_UNSIGNED_EN
   task automatic test_unsigned();
      int lat;
      exp_t e;
      for (int u = 1; u >= 0; u--) begin
         launch(32'hFFFFFFFF, 32'd2, u[0]);
         wait_done(lat);
         e = sb.pop_front();
         n_tests++;
         if (lat != 33 || lo !== e.lo || hi !== e.hi)
            begin n_fail++; $display("FAIL unsigned[%0d]: got lat=%0d lo=%h hi=%h want lat=33 lo=%h hi=%h", u, lat, lo, hi, e.lo, e.hi); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_signed();
      test_div0();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
`ifdef DIV_UNSIGNED_EN
      test_unsigned();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multicycle 32-bit signed integer divider for the DIV instruction.
- Receives operands from the A/B registers and a start strobe from the control FSM's divide control.
- Produces quotient (to LO) and remainder (to HI), plus a done strobe and a div0 flag.
- Feeds the control FSM's div0 exception input and the hidiv/lodiv register writes.
- Restoring division, one quotient bit per clock.

Parameters:
- WIDTH, 32, operand/result width; count register is clog2(WIDTH)+1 bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- dividend  input  WIDTH  rs value (A register).
- divisor  input  WIDTH  rt value (B register).
- lo  output  WIDTH  quotient, registered.
- hi  output  WIDTH  remainder, registered.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when lo/hi are updated.
- div0  output  1  one-cycle pulse when divisor is zero.

Behaviour:
- Reset (async, any state): state=IDLE; lo=hi=0; busy=done=div0=0; internal remainder, quotient, count and sign flags = 0.
- States: IDLE, RUN, FIX.
- IDLE, start=1, divisor==0:
  - div0=1 on the next cycle for exactly one cycle; stay IDLE.
  - done stays 0; lo/hi unchanged.
- IDLE, start=1, divisor!=0:
  - Latch |dividend|, |divisor|, neg_q = sign(dividend) XOR sign(divisor), neg_r = sign(dividend).
  - Clear partial remainder; count=0; busy=1; go RUN.
- RUN, one edge per bit, MSB first:
  - Shift {rem, quo} left 1.
  - trial = rem - |divisor| in WIDTH+1 bits.
  - trial non-negative: rem=trial, quotient LSB=1; otherwise quotient LSB=0.
  - count++; after WIDTH iterations go FIX.
- FIX:
  - lo = neg_q ? -quo : quo; hi = neg_r ? -rem : rem.
  - done=1 for this cycle only; busy=0; return to IDLE.
- Latency: start edge E0 → RUN edges E1..E32 → FIX edge E33. done and new lo/hi are visible after E33; back-to-back start is accepted at E34.
- Rounding: quotient truncates toward zero; remainder takes the dividend's sign; |hi| < |divisor|.
- Magnitudes are computed in WIDTH bits, so |0x80000000| = 0x80000000 unsigned.
- Overflow case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no trap, no div0.
- start while busy: ignored; the operation in flight is unaffected.
- dividend/divisor changes after the start edge: ignored (operands are latched).
- lo/hi hold their values until the next FIX; a div0 event does not touch them.
- Reset asserted mid-RUN: operation is abandoned; all outputs return to reset values immediately.
- done and div0 are never high in the same cycle.

Optional Feature:
- Macro: DIV_UNSIGNED_EN.
- Defined:
  - Adds input port div_unsigned (1 bit), sampled with start.
  - When div_unsigned=1, sign handling is bypassed (neg_q=neg_r=0, raw operands used) for DIVU.
  - Latency is unchanged.
- Undefined: port absent; all operations are signed.

Decomposition:
- Package div_pkg holds:
  - state enum (IDLE, RUN, FIX);
  - localparam DIV_WIDTH=32;
  - DIV_CNT_W = $clog2(DIV_WIDTH)+1;
  - a function for two's-complement absolute value.
- One combinational sub-module, div_step: inputs {rem, quo}, divisor magnitude; outputs the next {rem, quo} for one restoring iteration.
- The FSM, latches and sign fix stay in div_unit.

Test Plan:
- dividend=7, divisor=2, start → after 33 clocks done=1, lo=3, hi=1, busy low in the same cycle.
- dividend=-7 (0xFFFFFFF9), divisor=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); repeat with 7/-2 → lo=-3, hi=1.
- Preload lo=3, hi=1 from a prior op; dividend=5, divisor=0 → div0 pulse one cycle after start, no done, lo=3 and hi=1 retained, busy=0.
- 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, div0=0; then 0 / 5 → lo=0, hi=0.
- 100/7 started; second start (9/3) pulsed at cycle 10 → ignored, done at cycle 33 with lo=14, hi=2.
- 100/7 started; reset pulsed at cycle 10 → immediately lo=hi=0, busy=0; new 9/3 completes lo=3, hi=0.
- With DIV_UNSIGNED_EN: 0xFFFFFFFF/2 and div_unsigned=1 → lo=0x7FFFFFFF, hi=1; with div_unsigned=0 → lo=0, hi=0xFFFFFFFF.
